fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares one 8-bit FIFO write port between N_REQ byte producers (CRC/serializer channels). Each producer raises req with a stable byte. The arbiter grants one producer and latches its byte. It waits for fifo_busy low, pulses fifo_we for exactly one cycle, then acks the producer. It sits between the per-channel framing blocks and the shared output FIFO.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 8, byte width per requester
ID_W, 2, width of grant_id; must equal clog2(N_REQ)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
enable  input  1  global run enable; low freezes the FSM
req  input  N_REQ  per-requester write request, level; held until ack
data_in  input  N_REQ*DATA_W  flattened bytes; requester k owns bits [k*DATA_W +: DATA_W]
fifo_busy  input  1  FIFO cannot accept a write this cycle
fifo_we  output  1  registered one-cycle write strobe
fifo_data  output  DATA_W  registered write data; valid while fifo_we=1
ack  output  N_REQ  registered one-hot, one-cycle completion pulse to the winner
grant_id  output  ID_W  registered index of the current or last winner
busy  output  1  combinational; high when state != IDLE

Behaviour:
- Reset (sync, dominates enable): state=IDLE, fifo_we=0, fifo_data=0, ack=0, grant_id=0, rr pointer last=N_REQ-1, so requester 0 has first priority.
- enable=0: state, fifo_data, grant_id and last hold; fifo_we and ack are forced to 0 that cycle; FSM resumes where it stopped.
- States: IDLE, WAIT, ACK (plus HDR_WAIT and GAP under the option).
- IDLE: if any req bit is set, pick the first set bit scanning last+1, last+2, … mod N_REQ. Latch its byte into fifo_data, set grant_id, go to WAIT. Otherwise stay.
- WAIT: if fifo_busy=0, set fifo_we<=1 and go to ACK. Otherwise stay with fifo_we=0. Arrivals and removals of other req bits are ignored. fifo_data stays stable.
- ACK: fifo_we<=0, ack[grant_id]<=1, last<=grant_id, go to IDLE.
- IDLE clears ack<=0 on entry. The first IDLE evaluation happens one cycle after ack falls. A requester that drops req on the edge after ack is therefore never re-granted spuriously.
- Latency with fifo_busy=0:
  - req sampled in IDLE at edge E, then state WAIT.
  - fifo_we high after E+1, for one cycle.
  - ack high after E+2, for one cycle.
  - Next grant sampled at E+4.
  - Throughput is one byte per 4 cycles.
- fifo_we is never high on two consecutive cycles and never high while fifo_busy was high at the deciding edge.
- A requester still holding req after its ack gets its next turn only after every other pending requester has been served.
- fifo_busy stuck high: the FSM stays in WAIT indefinitely, with no timeout.
- Reset mid-transfer: the latched byte is discarded, no ack is issued, and the pending req is re-arbitrated from requester 0.

Optional Feature:
FIFO_ARB_TAG_EN
- Defined: each grant writes two bytes, a header then the payload. The header is {4'hA, grant_id zero-extended to 4 bits}, written first.
  - Flow: IDLE → HDR_WAIT (pulse fifo_we with the header when fifo_busy=0) → GAP (fifo_we<=0, fifo_data<=latched payload) → WAIT → ACK.
  - The payload is held in a separate register while the header is on fifo_data.
  - ack follows only the payload write.
  - Best-case throughput is one grant per 6 cycles.
- Undefined: no header, no extra states or registers; behaviour exactly as above.

Test Plan:
- Single request: reset, req=4'b0100 with data byte 2=8'h5C, fifo_busy=0 → fifo_we high once with fifo_data=8'h5C two edges after sampling; ack=4'b0100 on the following cycle; grant_id=2.
- Fairness: req=4'b1111 held and re-raised after each ack, 8 grants → grant order 0,1,2,3,0,1,2,3; exactly 8 fifo_we pulses, data matching each source.
- Backpressure: fifo_busy=1 for 5 cycles after grant → fifo_we stays 0 and fifo_data stays constant; fifo_we pulses on the first edge where fifo_busy=0; ack follows one cycle later.
- Enable freeze: drop enable for 3 cycles while in WAIT → no fifo_we or ack during the freeze; the transfer completes normally after re-enable with one fifo_we pulse.
- Reset mid-op: assert reset while in ACK (before the ack pulse) → ack never pulses; outputs zero next cycle; a still-asserted req=4'b0010 is granted afterwards (grant_id=1).
- Tag option (FIFO_ARB_TAG_EN): req on requester 3 with byte 8'h11 → fifo_we pulses carry 8'hA3 then 8'h11, separated by at least one low cycle; a single ack=4'b1000 after the second pulse.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between the per-channel producers and the shared output FIFO write port.
// The arbiter uses the slave modport; producers and the FIFO side use master.
interface fifo_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        ack;
  logic                    fifo_busy;
  logic                    fifo_we;
  logic [DATA_W-1:0]       fifo_data;

  modport master (
    output req, data_in, fifo_busy,
    input  ack, fifo_we, fifo_data
  );

  modport slave (
    input  req, data_in, fifo_busy,
    output ack, fifo_we, fifo_data
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ byte producers.
// Optional FIFO_ARB_TAG_EN: prefix every payload with a {4'hA, grant_id} header byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | clear ack after a completion, else arbitrate pending req
// HDR_WAIT | (tag build) header on fifo_data, wait for fifo_busy low
// GAP      | (tag build) drop strobe, move latched payload onto fifo_data
// WAIT     | payload on fifo_data, wait for fifo_busy low, then strobe
// ACK      | pulse ack to the winner and advance the rr pointer
module fifo_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  fifo_write_arbiter_if.slave   bus,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
);

`ifdef FIFO_ARB_TAG_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HDR_WAIT,
    S_GAP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;
`endif

  state_t              state_q, state_d;
  logic                fifo_we_q, fifo_we_d;
  logic [DATA_W-1:0]   fifo_data_q, fifo_data_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     last_q, last_d;
`ifdef FIFO_ARB_TAG_EN
  logic [DATA_W-1:0]   payload_q, payload_d;
`endif

  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     cand;
  logic [DATA_W-1:0]   pick_byte;

`ifdef FIFO_ARB_TAG_EN
  function automatic logic [DATA_W-1:0] header_byte(input logic [ID_W-1:0] id);
    logic [7:0] h;
    h = {4'hA, 4'(id)};
    return DATA_W'(h);
  endfunction
`endif

  // Scan last+1, last+2, ... wrapping at N_REQ (which need not be a power of two).
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = last_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
    pick_byte = bus.data_in[int'(pick_id)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d     = state_q;
    fifo_we_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    ack_d       = '0;
    grant_id_d  = grant_id_q;
    last_d      = last_q;
`ifdef FIFO_ARB_TAG_EN
    payload_d   = payload_q;
`endif
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          // A non-zero ack marks the completion cycle: give the winner a cycle to drop req.
          if (ack_q == '0 && pick_found) begin
            grant_id_d = pick_id;
`ifdef FIFO_ARB_TAG_EN
            fifo_data_d = header_byte(pick_id);
            payload_d   = pick_byte;
            state_d     = S_HDR_WAIT;
`else
            fifo_data_d = pick_byte;
            state_d     = S_WAIT;
`endif
          end
        end
`ifdef FIFO_ARB_TAG_EN
        S_HDR_WAIT: begin
          if (!bus.fifo_busy) begin
            fifo_we_d = 1'b1;
            state_d   = S_GAP;
          end
        end
        S_GAP: begin
          fifo_data_d = payload_q;
          state_d     = S_WAIT;
        end
`endif
        S_WAIT: begin
          if (!bus.fifo_busy) begin
            fifo_we_d = 1'b1;
            state_d   = S_ACK;
          end
        end
        S_ACK: begin
          ack_d[grant_id_q] = 1'b1;
          last_d            = grant_id_q;
          state_d           = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fifo_we_q   <= 1'b0;
      fifo_data_q <= '0;
      ack_q       <= '0;
      grant_id_q  <= '0;
      last_q      <= ID_W'(N_REQ - 1);
`ifdef FIFO_ARB_TAG_EN
      payload_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fifo_we_q   <= fifo_we_d;
      fifo_data_q <= fifo_data_d;
      ack_q       <= ack_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
`ifdef FIFO_ARB_TAG_EN
      payload_q   <= payload_d;
`endif
    end
  end

  assign bus.fifo_we   = fifo_we_q;
  assign bus.fifo_data = fifo_data_q;
  assign bus.ack       = ack_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q != S_IDLE);

endmodule
